// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, decoded codes and FSM states for the scan decoder
package seg_pkg;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;
  typedef enum logic {SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg7_to_code.sv
// seg7_to_code: inverse of the display's digit-to-segment decoder
module seg7_to_code
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);
  always_comb begin
    code = CODE_ERR;
    bad  = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   bad  = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: filters a multiplexed 7-segment bus and publishes decoded frames
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int N_DIGIT    = 6,
  parameter int STABLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_DIGIT-1:0]     i_seg_enb,
  input  logic                   i_seg_dp,
  input  logic [6:0]             i_seg,
  output logic [4*N_DIGIT-1:0]   o_digits,
  output logic [N_DIGIT-1:0]     o_dp,
  output logic                   o_frame_vld,
  output logic                   o_err,
  output logic [7:0]             o_frame_cnt
);
  localparam int SW = N_DIGIT + 8;
  localparam logic [SW-1:0] SMP_RST = {{N_DIGIT{1'b1}}, 8'b0};
  logic [SW-1:0] smp, smp_d;
  logic [7:0] cnt, cnt_nxt;
  state_t state, state_nxt;
  logic [N_DIGIT-1:0] en, mask, shadow_dp;
  logic [N_DIGIT-1:0][3:0] shadow;
  logic [3:0] code;
  logic bad, eq, fire, one, multi, cap, publish;
  seg7_to_code u_dec (.seg(smp[6:0]), .code(code), .bad(bad));
  assign en      = ~smp[SW-1:8];
  assign eq      = smp == smp_d;
  // fires on the edge where the count would reach STABLE_CYC-1
  assign fire    = state == SETTLE && eq && cnt == 8'(STABLE_CYC - 2);
  assign one     = en != '0 && (en & (en - {{(N_DIGIT-1){1'b0}}, 1'b1})) == '0;
  assign multi   = en != '0 && !one;
  assign cap     = fire && one;
  assign publish = &mask;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 8'd0;
    if (state == HOLD)
      state_nxt = eq ? HOLD : SETTLE;
    else if (fire)
      state_nxt = HOLD;
    else
      cnt_nxt = eq ? cnt + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      smp         <= SMP_RST;
      smp_d       <= SMP_RST;
      state       <= SETTLE;
      cnt         <= 8'd0;
      mask        <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      o_digits    <= '1;
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_err       <= 1'b0;
      o_frame_cnt <= 8'd0;
    end else begin
      smp         <= {i_seg_enb, i_seg_dp, i_seg};
      smp_d       <= smp;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_frame_vld <= publish;
      mask        <= (publish ? '0 : mask) | (cap ? en : '0);
      if (publish) begin
        o_digits    <= shadow;
        o_dp        <= shadow_dp;
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end
      for (int i = 0; i < N_DIGIT; i++)
        if (cap && en[i]) begin
          shadow[i]    <= code;
          shadow_dp[i] <= smp[7];
        end
      if (fire && (multi || (one && bad)))
        o_err <= 1'b1;
    end
  end
endmodule
